// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transmitter.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;

    localparam int SPI_BITS        = 8;
    localparam int SPI_CLK_DIV_MIN = 6;

    function automatic int spi_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK phase generator: CLK_DIV cycles low then CLK_DIV cycles high per bit while en is high.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb,
    output logic last_bit
);

    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(SPI_BITS);

    logic [PH_W-1:0]  phase_q;
    logic [BIT_W-1:0] bit_q;
    logic             ph_end;

    assign ph_end = (phase_q == PH_W'(CLK_DIV - 1));

    // Everything restarts from the first low phase whenever SHIFT is not active.
    always_ff @(posedge clk_in) begin
        if (rst_in || !en) begin
            phase_q  <= '0;
            bit_q    <= '0;
            sck      <= 1'b0;
            rise_stb <= 1'b0;
        end else begin
            rise_stb <= ph_end && !sck;
            if (ph_end) begin
                phase_q <= '0;
                sck     <= !sck;
                if (sck) bit_q <= bit_q + BIT_W'(1);
            end else begin
                phase_q <= phase_q + PH_W'(1);
            end
        end
    end

    // rise_stb marks the first high cycle; fall_stb marks the last high cycle.
    assign fall_stb = en && ph_end && sck;
    assign last_bit = (bit_q == BIT_W'(SPI_BITS - 1));

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master, one MSB-first byte per CS frame.
// Define SPI_RX_CAPTURE_EN to capture MISO into rx_data; otherwise rx_data reads 0x00.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 8,
    parameter int CS_HOLD  = 8,
    parameter int CS_GAP   = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       spi_cs,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int CNT_W = $clog2(spi_max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

    if (CLK_DIV < SPI_CLK_DIV_MIN) begin : g_bad_clk_div
        $error("spi_master_tx: CLK_DIV must be at least %0d", SPI_CLK_DIV_MIN);
    end
    if (CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 1) begin : g_bad_cs_timing
        $error("spi_master_tx: CS_SETUP, CS_HOLD and CS_GAP must be at least 1");
    end

    spi_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SPI_BITS-1:0] tx_shift;
    logic                accept, cs_d, ready_d, busy_d, done_d;
    logic                rise_stb, fall_stb, last_bit;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en       (state_q == SHIFT),
        .sck      (spi_sck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (tx_valid) begin
                accept  = 1'b1;
                state_d = SETUP;
                cnt_d   = CNT_W'(CS_SETUP - 1);
            end
            SETUP: if (cnt_q == '0) state_d = SHIFT;
                   else cnt_d = cnt_q - CNT_W'(1);
            SHIFT: if (fall_stb && last_bit) begin
                state_d = HOLD;
                cnt_d   = CNT_W'(CS_HOLD - 1);
            end
            HOLD: if (cnt_q == '0) begin
                state_d = GAP;
                cnt_d   = CNT_W'(CS_GAP - 1);
            end else cnt_d = cnt_q - CNT_W'(1);
            GAP: if (cnt_q == '0) state_d = IDLE;
                 else cnt_d = cnt_q - CNT_W'(1);
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        cs_d    = !(state_d inside {SETUP, SHIFT, HOLD});
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == HOLD) && (state_d == GAP);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            spi_cs   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            spi_cs   <= cs_d;
            tx_ready <= ready_d;
            busy     <= busy_d;
            done     <= done_d;
            // MOSI moves only on SCK fall, never after the final bit.
            if (accept)                     spi_mosi <= tx_data[SPI_BITS-1];
            else if (fall_stb && !last_bit) spi_mosi <= tx_shift[SPI_BITS-2];
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept)                     tx_shift <= tx_data;
        else if (fall_stb && !last_bit) tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
    end

`ifdef SPI_RX_CAPTURE_EN
    logic [SPI_BITS-1:0] rx_shift;

    always_ff @(posedge clk_in) begin
        if (rise_stb) rx_shift <= {rx_shift[SPI_BITS-2:0], spi_miso};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)      rx_data <= '0;
        else if (done_d) rx_data <= rx_shift;
    end
`else
    logic unused_rx;

    assign unused_rx = spi_miso ^ rise_stb;
    assign rx_data   = '0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx against a cycle-offset model of one CS frame.
module tb_spi_master_tx;

    localparam int DIV = 8, SU = 8, HO = 8, GP = 16;
    localparam int SH_START  = 1 + SU;
    localparam int SH_END    = SH_START + 16 * DIV - 1;
    localparam int GAP_START = SH_END + 1 + HO;
    localparam int IDLE_AT   = GAP_START + GP;

    logic       clk_in = 1'b0;
    logic       rst_in, tx_valid, tx_ready, busy, done;
    logic       spi_cs, spi_sck, spi_mosi, spi_miso, loopback, miso_drv;
    logic [7:0] tx_data, rx_data, exp_rx;
    int         errors = 0, checks = 0, done_cnt = 0, cur_off = 0;

    always #5 clk_in = ~clk_in;

    assign spi_miso = loopback ? spi_mosi : miso_drv;

    spi_master_tx #(.CLK_DIV(DIV), .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .spi_cs   (spi_cs),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s at off=%0d observed=%0h expected=%0h", tag, cur_off, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    function automatic int bit_idx(input int off);
        return (off < SH_START) ? 0 : (off - SH_START) / (2 * DIV);
    endfunction

    function automatic logic exp_sck(input int off);
        return (off >= SH_START && off <= SH_END && ((off - SH_START) / DIV) % 2 == 1);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cur_off = -1;
            chk("idle_cs", spi_cs, 1);
            chk("idle_sck", spi_sck, 0);
            chk("idle_busy", busy, 0);
            chk("idle_ready", tx_ready, 1);
            chk("idle_done", done, 0);
            chk("idle_rx", rx_data, exp_rx);
        end
    endtask

    // mode 0: single frame; mode 1: hold valid with nxt for a back-to-back frame;
    // mode 2: offer 0xFF while busy and scribble tx_data mid-frame.
    task automatic frame(input logic [7:0] b, input logic [7:0] rxpat, input int mode,
                         input logic [7:0] nxt, input int stop_at);
        logic [7:0] cap;
        cap      = loopback ? b : rxpat;
        tx_valid = 1'b1;
        tx_data  = b;
        cur_off  = 0;
        chk("ready_at_accept", tx_ready, 1);
        for (int off = 1; off <= stop_at; off++) begin
            step();
            cur_off = off;
`ifdef SPI_RX_CAPTURE_EN
            if (off == GAP_START) exp_rx = cap;
`endif
            chk("cs", spi_cs, (off >= 1 && off < GAP_START) ? 0 : 1);
            chk("sck", spi_sck, exp_sck(off));
            chk("busy", busy, (off < IDLE_AT) ? 1 : 0);
            chk("ready", tx_ready, (off >= IDLE_AT) ? 1 : 0);
            chk("done", done, (off == GAP_START) ? 1 : 0);
            chk("rx_data", rx_data, exp_rx);
            if (off <= SH_END) chk("mosi", spi_mosi, b[7 - bit_idx(off)]);
            if (off <= SH_END) miso_drv = rxpat[7 - bit_idx(off)];
            if (mode == 0 && off == 1) begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
            end
            if (mode == 1 && off == 1) tx_data = nxt;
            if (mode == 2) begin
                if (off == 1)   tx_valid = 1'b0;
                if (off == 20) begin tx_valid = 1'b1; tx_data = 8'hFF; end
                if (off == 30)  tx_data = 8'h00;
                if (off == 140) tx_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int d0;
        rst_in   = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        loopback = 1'b0;
        miso_drv = 1'b0;
        exp_rx   = 8'h00;
        repeat (3) step();
        cur_off = -1;
        chk("rst_cs", spi_cs, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        rst_in = 1'b0;
        idle(3);

        frame(8'hA5, 8'($urandom), 0, 8'h00, IDLE_AT);
        idle(2);

        done_cnt = 0;
        frame(8'h3C, 8'($urandom), 1, 8'hC3, IDLE_AT);
        frame(8'hC3, 8'($urandom), 0, 8'h00, IDLE_AT);
        chk("b2b_done_count", done_cnt, 2);
        idle(2);

        frame(8'h81, 8'($urandom), 2, 8'h00, IDLE_AT);
        idle(5);

        d0 = done_cnt;
        frame(8'($urandom), 8'($urandom), 0, 8'h00, 60);
        rst_in = 1'b1;
        step();
        rst_in  = 1'b0;
        cur_off = 61;
        exp_rx  = 8'h00;
        chk("midrst_cs", spi_cs, 1);
        chk("midrst_sck", spi_sck, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_rx", rx_data, 0);
        idle(20);
        chk("midrst_no_done", done_cnt, d0);
        frame(8'h0F, 8'($urandom), 0, 8'h00, IDLE_AT);
        idle(1);

        loopback = 1'b1;
        frame(8'h5A, 8'h00, 0, 8'h00, IDLE_AT);
        loopback = 1'b0;
`ifdef SPI_RX_CAPTURE_EN
        chk("loopback_rx", rx_data, 8'h5A);
`else
        chk("loopback_rx", rx_data, 8'h00);
`endif
        idle(1);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] rb, nb;
            rb = 8'($urandom);
            nb = 8'($urandom);
            frame(rb, 8'($urandom), 1, nb, IDLE_AT);
            frame(nb, 8'($urandom), 0, 8'h00, IDLE_AT);
            idle($urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
